// File: rtl/uphi_pkg.sv
// Shared types and constants for the UPHI DAC streamer.
package uphi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_ACT = 3'd2,
    STREAM   = 3'd3,
    FLUSH    = 3'd4,
    DONE     = 3'd5
  } uphi_stream_state_t;

  localparam int          CAPTURE_PHASE_DEF = 2;
  localparam logic [31:0] INVALID_VOL       = '1;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uphi_dac_wr_gen.sv
// DAC strobe sequencer: a write request becomes setup / WR_n-low / hold,
// and an LDAC request drives LDAC_n low four cycles after it is raised.
module uphi_dac_wr_gen (
  input  logic clk_in,
  input  logic rst_in,
  input  logic wr_req,
  input  logic ldac_req,
  output logic dac_wr_n,
  output logic dac_ldac_n,
  output logic pending
);

  logic       wr_setup_r;
  logic       wr_n_r;
  logic [2:0] ldac_pipe_r;
  logic       ldac_n_r;

  // Strobe pipelines for the write pulse and the delayed load pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_setup_r  <= 1'b0;
      wr_n_r      <= 1'b1;
      ldac_pipe_r <= 3'b000;
      ldac_n_r    <= 1'b1;
    end else begin
      wr_setup_r  <= wr_req;
      wr_n_r      <= ~wr_setup_r;
      ldac_pipe_r <= {ldac_pipe_r[1:0], ldac_req};
      ldac_n_r    <= ~ldac_pipe_r[2];
    end
  end

  // The LDAC low cycle itself is not pending so the frame can close right after it
  assign pending    = wr_setup_r | ~wr_n_r | (|ldac_pipe_r);
  assign dac_wr_n   = wr_n_r;
  assign dac_ldac_n = ldac_n_r;

endmodule

// File: rtl/uphi_dac_streamer.sv
// Streams one UPHI frame into a parallel-bus DAC with grouped LDAC pulses.
// Optional macro UPHI_STREAM_SKIP_INVALID_EN suppresses writes of all-ones samples.
module uphi_dac_streamer
  import uphi_pkg::*;
#(
  parameter int VOL_WIDTH     = 8,
  parameter int VOL_NUM       = 720,
  parameter int CH_PER_GROUP  = 8,
  parameter int CAPTURE_PHASE = CAPTURE_PHASE_DEF,
  parameter int TIMEOUT       = 4096,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  arm,
  input  logic                  uphi_active,
  input  logic [VOL_WIDTH-1:0]  uphi_vol,
  input  logic [1:0]            uphi_read_cnt,
  output logic                  uphi_start,
  output logic [VOL_WIDTH-1:0]  dac_data,
  output logic [ADDR_WIDTH-1:0] dac_addr,
  output logic                  dac_wr_n,
  output logic                  dac_ldac_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic                  err_short
);

  localparam int GRP_W = (clog2(CH_PER_GROUP) < 1) ? 1 : clog2(CH_PER_GROUP);
  localparam int TO_W  = clog2(TIMEOUT + 1);

  localparam logic [1:0]            CAP_PH   = 2'(CAPTURE_PHASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VOL_NUM - 1);
  localparam logic [GRP_W-1:0]      LAST_GRP = GRP_W'(CH_PER_GROUP - 1);
  localparam logic [TO_W-1:0]       LAST_TO  = TO_W'(TIMEOUT - 1);

  uphi_stream_state_t state_r;
  uphi_stream_state_t state_s;

  logic [TO_W-1:0]       tcnt_r;
  logic [ADDR_WIDTH-1:0] sample_idx_r;
  logic [GRP_W-1:0]      grp_cnt_r;
  logic                  act_d_r;
  logic                  flush_ld_r;
  logic [VOL_WIDTH-1:0]  data_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  start_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_to_r;
  logic                  err_sh_r;

  logic capture_s;
  logic invalid_s;
  logic cap_s;
  logic wr_req_s;
  logic ldac_req_s;
  logic clr_err_s;
  logic set_to_s;
  logic set_sh_s;
  logic init_s;
  logic tcnt_inc_s;
  logic set_fl_s;
  logic pending_s;

  assign capture_s = uphi_active & (uphi_read_cnt == CAP_PH);

`ifdef UPHI_STREAM_SKIP_INVALID_EN
  localparam logic [VOL_WIDTH-1:0] INVALID = INVALID_VOL[VOL_WIDTH-1:0];
  assign invalid_s = (uphi_vol == INVALID);
`else
  assign invalid_s = 1'b0;
`endif

  // Skipped samples still occupy an address and a group slot
  assign wr_req_s = cap_s & ~invalid_s;

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_s    = state_r;
    clr_err_s  = 1'b0;
    set_to_s   = 1'b0;
    set_sh_s   = 1'b0;
    init_s     = 1'b0;
    tcnt_inc_s = 1'b0;
    cap_s      = 1'b0;
    ldac_req_s = 1'b0;
    set_fl_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm) begin
          clr_err_s = 1'b1;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        init_s  = 1'b1;
        state_s = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (uphi_active && !act_d_r) begin
          state_s = STREAM;
        end else if (tcnt_r == LAST_TO) begin
          set_to_s = 1'b1;
          state_s  = IDLE;
        end else begin
          tcnt_inc_s = 1'b1;
        end
      end
      STREAM: begin
        if (capture_s) begin
          cap_s = 1'b1;
          if (grp_cnt_r == LAST_GRP) begin
            ldac_req_s = 1'b1;
          end else begin
            ldac_req_s = 1'b0;
          end
          if (sample_idx_r == LAST_IDX) begin
            state_s = FLUSH;
          end else begin
            state_s = STREAM;
          end
        end else if (!uphi_active) begin
          set_sh_s = 1'b1;
          state_s  = FLUSH;
        end else begin
          state_s = STREAM;
        end
      end
      FLUSH: begin
        if (pending_s) begin
          state_s = FLUSH;
        end else if ((grp_cnt_r != {GRP_W{1'b0}}) && !flush_ld_r) begin
          ldac_req_s = 1'b1;
          set_fl_s   = 1'b1;
          state_s    = FLUSH;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Counters, bus latches and registered status outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tcnt_r       <= {TO_W{1'b0}};
      sample_idx_r <= {ADDR_WIDTH{1'b0}};
      grp_cnt_r    <= {GRP_W{1'b0}};
      act_d_r      <= 1'b0;
      flush_ld_r   <= 1'b0;
      data_r       <= {VOL_WIDTH{1'b0}};
      addr_r       <= {ADDR_WIDTH{1'b0}};
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_to_r     <= 1'b0;
      err_sh_r     <= 1'b0;
    end else begin
      act_d_r <= uphi_active;
      start_r <= (state_r == START);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_r == DONE);

      if (clr_err_s) begin
        err_to_r <= 1'b0;
        err_sh_r <= 1'b0;
      end else begin
        if (set_to_s) err_to_r <= 1'b1;
        if (set_sh_s) err_sh_r <= 1'b1;
      end

      if (init_s) begin
        tcnt_r       <= {TO_W{1'b0}};
        sample_idx_r <= {ADDR_WIDTH{1'b0}};
        grp_cnt_r    <= {GRP_W{1'b0}};
        flush_ld_r   <= 1'b0;
      end else begin
        if (tcnt_inc_s) tcnt_r <= tcnt_r + TO_W'(1);
        if (cap_s) begin
          data_r       <= uphi_vol;
          addr_r       <= sample_idx_r;
          sample_idx_r <= sample_idx_r + ADDR_WIDTH'(1);
          grp_cnt_r    <= (grp_cnt_r == LAST_GRP) ? {GRP_W{1'b0}} : grp_cnt_r + GRP_W'(1);
        end
        if (set_fl_s) flush_ld_r <= 1'b1;
      end
    end
  end

  uphi_dac_wr_gen u_wr_gen (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_req     (wr_req_s),
    .ldac_req   (ldac_req_s),
    .dac_wr_n   (dac_wr_n),
    .dac_ldac_n (dac_ldac_n),
    .pending    (pending_s)
  );

  assign uphi_start  = start_r;
  assign dac_data    = data_r;
  assign dac_addr    = addr_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign err_timeout = err_to_r;
  assign err_short   = err_sh_r;

endmodule

// File: tb/tb_uphi_dac_streamer.sv
// Randomized scoreboard bench for uphi_dac_streamer with an upstream slot model.
module tb_uphi_dac_streamer;
  import uphi_pkg::*;

  localparam int VW  = 8;
  localparam int VN  = 720;
  localparam int CPG = 8;
  localparam int AW  = 10;
  localparam int TO  = 4096;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          arm = 1'b0;
  logic          uphi_active = 1'b0;
  logic [VW-1:0] uphi_vol = '0;
  logic [1:0]    uphi_read_cnt = 2'd0;
  logic          uphi_start;
  logic [VW-1:0] dac_data;
  logic [AW-1:0] dac_addr;
  logic          dac_wr_n;
  logic          dac_ldac_n;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;
  logic          err_short;

  uphi_dac_streamer #(
    .VOL_WIDTH(VW), .VOL_NUM(VN), .CH_PER_GROUP(CPG),
    .CAPTURE_PHASE(2), .TIMEOUT(TO), .ADDR_WIDTH(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .arm(arm),
    .uphi_active(uphi_active), .uphi_vol(uphi_vol), .uphi_read_cnt(uphi_read_cnt),
    .uphi_start(uphi_start), .dac_data(dac_data), .dac_addr(dac_addr),
    .dac_wr_n(dac_wr_n), .dac_ldac_n(dac_ldac_n), .busy(busy),
    .frame_done(frame_done), .err_timeout(err_timeout), .err_short(err_short)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_exp_t;
  typedef struct { int addr; int cyc; } ld_exp_t;
  wr_exp_t wr_q[$];
  ld_exp_t ld_q[$];

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  int ld_seen = 0;
  int last_ldac_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit skipped(input logic [VW-1:0] v);
`ifdef UPHI_STREAM_SKIP_INVALID_EN
    return v == 8'hFF;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT strobes the DAC
  initial begin
    wr_exp_t we;
    ld_exp_t le;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (uphi_start) start_cnt++;
        if (frame_done) begin
          done_cnt++;
          if (last_ldac_cyc >= 0) check("done_after_ldac", cyc - last_ldac_cyc, 2);
        end
        if (!dac_wr_n) begin
          wr_seen++;
          if (wr_q.size() == 0) begin
            check("unexpected_wr_addr", int'(dac_addr), -1);
          end else begin
            we = wr_q.pop_front();
            check("wr_addr", int'(dac_addr), we.addr);
            check("wr_data", int'(dac_data), we.data);
            check("wr_latency", cyc - we.cyc, 2);
          end
        end
        if (!dac_ldac_n) begin
          ld_seen++;
          last_ldac_cyc = cyc;
          if (ld_q.size() == 0) begin
            check("unexpected_ldac_addr", int'(dac_addr), -1);
          end else begin
            le = ld_q.pop_front();
            check("ldac_last_addr", int'(dac_addr), le.addr);
            if (le.cyc >= 0) check("ldac_latency", cyc, le.cyc);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    start_cnt = 0; done_cnt = 0; wr_seen = 0; ld_seen = 0; last_ldac_cyc = -1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_n"}, int'(dac_wr_n), 1);
    check({tag, "_ldac_n"}, int'(dac_ldac_n), 1);
    check({tag, "_data"}, int'(dac_data), 0);
    check({tag, "_addr"}, int'(dac_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_start"}, int'(uphi_start), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_errs"}, int'({err_timeout, err_short}), 0);
  endtask

  // Arm pulse; busy expected one cycle later, uphi_start two cycles later
  task automatic do_arm();
    @(negedge clk_in);
    arm = 1'b1;
    @(negedge clk_in);
    arm = 1'b0;
    check("busy_after_arm", int'(busy), 1);
    @(negedge clk_in);
    check("start_after_arm", int'(uphi_start), 1);
  endtask

  // mode: 0 ramp, 1 random, 2 random never all-ones; n_inv leading 8'hFF samples
  task automatic run_frame(input int n_caps, input int mode, input int n_inv,
                           input int arm_at, input int rst_at);
    logic [VW-1:0] v;
    int n_wr;
    int t;
    n_wr = 0;
    clear_counts();
    do_arm();
    repeat ($urandom_range(1, 12)) @(negedge clk_in);
    uphi_active = 1'b1;
    for (int s = 0; s < n_caps; s++) begin
      for (int ph = 0; ph < 4; ph++) begin
        uphi_read_cnt = ph[1:0];
        arm = (s == arm_at && ph == 0) ? 1'b1 : 1'b0;
        if (ph == 2) begin
          case (mode)
            0:       v = s[7:0];
            1:       v = 8'($urandom);
            default: v = 8'($urandom_range(0, 254));
          endcase
          if (s < n_inv) v = 8'hFF;
          uphi_vol = v;
          if (s == rst_at) begin
            #1 rst_in = 1'b0;
            #1 check_reset_values("midrst");
            wr_q.delete();
            ld_q.delete();
            uphi_active = 1'b0;
            uphi_read_cnt = 2'd0;
            arm = 1'b0;
            repeat (2) @(negedge clk_in);
            rst_in = 1'b1;
            @(negedge clk_in);
            return;
          end
          if (!skipped(v)) begin
            wr_q.push_back('{s, int'(v), cyc});
            n_wr++;
          end
          if (s % CPG == CPG - 1) ld_q.push_back('{s, cyc + 4});
          else if (s == n_caps - 1) ld_q.push_back('{s, -1});
        end else begin
          uphi_vol = 8'($urandom);
        end
        @(negedge clk_in);
      end
    end
    uphi_active = 1'b0;
    uphi_read_cnt = 2'd0;
    arm = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    repeat (3) @(negedge clk_in);
    check("frame_done_count", done_cnt, 1);
    check("start_pulses", start_cnt, 1);
    check("wr_count", wr_seen, n_wr);
    check("ldac_count", ld_seen, (n_caps + CPG - 1) / CPG);
    check("wr_q_left", wr_q.size(), 0);
    check("ld_q_left", ld_q.size(), 0);
    check("err_short", int'(err_short), (n_caps < VN) ? 1 : 0);
    check("err_timeout_clr", int'(err_timeout), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic run_timeout();
    int ts;
    int t;
    clear_counts();
    do_arm();
    ts = cyc;
    t = 0;
    while (!err_timeout && t < TO + 100) begin
      @(negedge clk_in);
      t++;
    end
    check("timeout_latency", cyc - ts, TO);
    check("timeout_busy", int'(busy), 0);
    check("timeout_writes", wr_seen, 0);
    check("timeout_ldacs", ld_seen, 0);
    repeat (4) @(negedge clk_in);
    check("timeout_no_done", done_cnt, 0);
    check("timeout_sticky", int'(err_timeout), 1);
    check("timeout_no_short", int'(err_short), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check_reset_values("rst");
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    run_frame(VN, 0, 0, -1, -1);
    run_frame(VN, 2, 4, -1, -1);
    run_timeout();
    run_frame(13, 0, 0, -1, -1);
    run_frame(VN, 0, 0, -1, 100);
    run_frame(VN, 0, 0, -1, -1);
    run_frame(VN, 1, 0, 300, -1);
    for (int k = 0; k < 3; k++) begin
      run_frame($urandom_range(1, 40), 1, $urandom_range(0, 3), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
